i2c_slave_mem: RTL
==================

Name: i2c_slave_mem

Overview:
- I2C target (responder) that emulates a byte-addressable EEPROM/register device on the same bus our I2C master drives.
- Samples the externally driven i2c_scl and answers on i2c_sda by open-drain pull-down only.
- Supports random write, sequential write, current-address read and random read (repeated START), with auto-incrementing word address.
- Lets the master path be exercised on-board or in simulation without a real EEPROM.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address this target responds to.
- MEM_DEPTH, 256, number of bytes in internal memory; must be a power of 2, at most 256 (or 65536 with ADDR16_EN).
- FILT_LEN, 3, consecutive identical synchronized samples needed to accept a new SCL/SDA level (glitch filter).

Ports:
- clk  input  1  system clock; at least 20x the SCL frequency.
- rst  input  1  synchronous, active-high reset.
- i2c_scl  input  1  bus clock from master.
- i2c_sda  inout  1  bus data; driven 1'b0 when pulling low, else 1'bz.
- wr_pulse  output  1  one-cycle strobe when a received data byte is committed to memory.
- wr_addr  output  16  word address of the committed byte (upper bits 0 in 8-bit mode).
- wr_byte  output  8  committed data byte.
- busy  output  1  high from an addressed START match until STOP or NACK.

Behaviour:
- Input path
  - 2-FF synchronizer on SCL and SDA (SDA read via the inout).
  - Then a FILT_LEN majority-run filter producing scl_f and sda_f.
  - Edge detects: scl_rise, scl_fall.
  - START = sda_f falls while scl_f is high. STOP = sda_f rises while scl_f is high.
- Bus sampling and driving
  - Bits are shifted MSB first on scl_rise.
  - The SDA drive (sda_pull) changes only on the clk cycle after scl_fall. It is never changed while scl_f is high.
- Reset values
  - sda_pull=0 (bus released); wr_pulse=0; wr_addr=0; wr_byte=0; busy=0.
  - Word address pointer = 0; FSM = IDLE.
  - Memory contents are not reset.
- FSM states
  - IDLE: wait for START.
  - DEVADDR: shift 8 bits (7 address bits + R/W).
  - DEVACK: if the address equals DEV_ADDR, pull SDA for one SCL period and go to WA_H / WA_L (W=0) or RD_LOAD (R=1). If not, release SDA and go to IDLE; ignore traffic until the next START.
  - WA_H: high word-address byte; present only with ADDR16_EN. ACK it, then go to WA_L.
  - WA_L: low word-address byte. Load the pointer (masked to MEM_DEPTH-1), ACK, go to WDATA.
  - WDATA: receive a byte, then ACK. On the ACK scl_fall:
    - mem[ptr] <= byte;
    - wr_pulse=1 for one cycle, with wr_addr=ptr and wr_byte=byte;
    - ptr <= (ptr+1) mod MEM_DEPTH (wraps to 0);
    - stay in WDATA.
  - RD_LOAD: load shift register with mem[ptr], go to RDATA.
  - RDATA: drive 8 bits, pull SDA low for '0' bits. After the 8th bit, release SDA, ptr <= ptr+1 (wrapping), go to RACK.
  - RACK: sample master ACK on scl_rise. ACK (SDA=0) goes to RD_LOAD. NACK (SDA=1) goes to IDLE and waits for STOP/START.
- Boundary conditions
  - START in any state: abort the current byte, release SDA, go to DEVADDR. Repeated START keeps ptr, giving a random read.
  - STOP in any state: release SDA, go to IDLE, busy=0. A partial byte is discarded and not written.
  - A write with only the word address and no data sets ptr only; no wr_pulse.
  - General-call address 7'h00 is not acknowledged.
  - rst asserted mid-transfer: SDA released within 1 clk; FSM goes to IDLE next cycle.

Optional Feature:
- Macro: I2C_SLAVE_ADDR16_EN.
- Defined: two word-address bytes, high byte first; ptr is 16 bits masked to MEM_DEPTH-1. This matches the master's 16-bit address mode.
- Undefined: a single word-address byte; wr_addr[15:8]=0; WA_H is never entered.

Test Plan:
- Single write: bus model sends START, 0xA0, 0x12, 0x5A, STOP.
  - Three target ACKs observed.
  - One wr_pulse with wr_addr=0x0012, wr_byte=0x5A; mem[0x12]=0x5A.
- Random read: after the write above, send START, 0xA0, 0x12, repeated START, 0xA1, read 1 byte, master NACK, STOP.
  - Byte read = 0x5A; SDA released after the NACK; busy=0 after STOP.
- Sequential write across wrap: with MEM_DEPTH=256, write 0x11, 0x22, 0x33 starting at 0xFE.
  - wr_addr sequence is 0xFE, 0xFF, 0x00.
  - A following current-address read returns mem[0x01].
- Wrong address: send START, 0xA2, 0x00, 0x55, STOP.
  - No ACK (SDA stays high through all ACK slots); no wr_pulse; busy stays 0.
- Abort mid-byte: send START, 0xA0, 0x20, 4 data bits, then STOP.
  - No wr_pulse; mem[0x20] unchanged.
  - A new transaction started 2 SCL periods later is ACKed normally.
- I2C_SLAVE_ADDR16_EN build with MEM_DEPTH=4096: write 0x0A, 0xBC, data 0x77.
  - wr_addr=0x0ABC; a random read at 0x0ABC returns 0x77.
  - Assert rst during the data byte: SDA goes to Z within 1 clk.

Source files
------------

// File: rtl/i2c_slave_mem_if.sv
// Bus-side bundle for the I2C EEPROM emulator: SCL from the master
// plus the write-commit strobe and busy status seen by the host side.
interface i2c_slave_mem_if;
  logic        i2c_scl;
  logic        wr_pulse;
  logic [15:0] wr_addr;
  logic [7:0]  wr_byte;
  logic        busy;

  modport slave (
    input  i2c_scl,
    output wr_pulse, wr_addr, wr_byte, busy
  );

  modport master (
    output i2c_scl,
    input  wr_pulse, wr_addr, wr_byte, busy
  );
endinterface

// File: rtl/i2c_slave_mem.sv
// I2C target emulating a byte-addressable EEPROM with auto-increment.
// Define I2C_SLAVE_ADDR16_EN for two-byte (high first) word addressing.
module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 256,
  parameter int         FILT_LEN  = 3
) (
  input  logic            clk,
  input  logic            rst,
  inout  wire             i2c_sda,
  i2c_slave_mem_if.slave  bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(FILT_LEN) + 1;

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, WA_H, WA_L,
    WDATA, RD_LOAD, RDATA, RACK
  } state_t;

  state_t        state, nxt;
  logic [1:0]    s1, s2, f, fd;
  logic [CW-1:0] cnt [2];
  logic          scl_f, sda_f;
  logic          scl_rise, scl_fall;
  logic          start, stop;
  logic          sda_pull, pull_nxt;
  logic [3:0]    bitcnt, bit_nxt;
  logic [7:0]    shift;
  logic [AW-1:0] ptr;
  logic [7:0]    mem [MEM_DEPTH];
  logic          pulse;
  logic [15:0]   waddr;
  logic [7:0]    wbyte;
  logic          busy_st;
  logic          rx, shift_en, byte_done, ack_done;
  logic          match, rw;
  logic          commit, ld_lo, rd_ld, rd_shift, rd_end;
  logic          busy_set, busy_clr;
`ifdef I2C_SLAVE_ADDR16_EN
  logic [7:0]    hi;
`endif

  assign i2c_sda      = sda_pull ? 1'b0 : 1'bz;
  assign bus.wr_pulse = pulse;
  assign bus.wr_addr  = waddr;
  assign bus.wr_byte  = wbyte;
  assign bus.busy     = busy_st;

  // bit 1 = SCL, bit 0 = SDA; a new level needs FILT_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 2'b11;
      s2     <= 2'b11;
      f      <= 2'b11;
      fd     <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= {bus.i2c_scl, i2c_sda};
      s2 <= s1;
      fd <= f;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == f[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
          f[i]   <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign scl_f    = f[1];
  assign sda_f    = f[0];
  assign scl_rise = scl_f & ~fd[1];
  assign scl_fall = ~scl_f & fd[1];
  assign start    = scl_f & fd[1] & fd[0] & ~sda_f;
  assign stop     = scl_f & fd[1] & ~fd[0] & sda_f;

  assign rx = (state == DEVADDR) || (state == WA_H) ||
              (state == WA_L) || (state == WDATA);
  assign shift_en  = rx && scl_rise && (bitcnt < 4'd8);
  assign byte_done = rx && scl_fall && (bitcnt == 4'd8);
  assign ack_done  = rx && scl_fall && (bitcnt == 4'd9);
  assign match     = (shift[7:1] == DEV_ADDR) && (shift[7:1] != 7'h00);
  assign rw        = shift[0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start) begin
      nxt = DEVADDR;
    end else if (stop) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    nxt = IDLE;
        DEVADDR: if (byte_done) nxt = match ? DEVACK : IDLE;
        DEVACK: begin
          if (rw && scl_rise)
            nxt = RD_LOAD;
          else if (!rw && scl_fall)
`ifdef I2C_SLAVE_ADDR16_EN
            nxt = WA_H;
`else
            nxt = WA_L;
`endif
        end
        WA_H:    if (ack_done) nxt = WA_L;
        WA_L:    if (ack_done) nxt = WDATA;
        WDATA:   nxt = WDATA;
        RD_LOAD: nxt = RDATA;
        RDATA:   if (scl_fall && bitcnt == 4'd8) nxt = RACK;
        RACK:    if (scl_rise) nxt = sda_f ? IDLE : RD_LOAD;
        default: nxt = IDLE;
      endcase
    end
  end

  // SDA drive only ever moves on an scl_fall, so it settles while SCL is low
  always_comb begin
    pull_nxt = sda_pull;
    commit   = 1'b0;
    ld_lo    = 1'b0;
    rd_ld    = 1'b0;
    rd_shift = 1'b0;
    rd_end   = 1'b0;
    busy_set = 1'b0;
    busy_clr = stop;
    if (start || stop) begin
      pull_nxt = 1'b0;
    end else begin
      unique case (state)
        DEVADDR: if (byte_done) begin
          pull_nxt = match;
          busy_set = match;
          busy_clr = !match;
        end
        DEVACK: if (!rw && scl_fall) pull_nxt = 1'b0;
        WA_H, WA_L, WDATA: begin
          if (byte_done) begin
            pull_nxt = 1'b1;
            ld_lo    = (state == WA_L);
            commit   = (state == WDATA);
          end else if (ack_done) begin
            pull_nxt = 1'b0;
          end
        end
        RD_LOAD: rd_ld = 1'b1;
        RDATA: if (scl_fall) begin
          if (bitcnt < 4'd8) begin
            pull_nxt = ~shift[7];
            rd_shift = 1'b1;
          end else begin
            pull_nxt = 1'b0;
            rd_end   = 1'b1;
          end
        end
        RACK: busy_clr = scl_rise && sda_f;
        IDLE: pull_nxt = sda_pull;
        default: pull_nxt = 1'b0;
      endcase
    end
    bit_nxt = bitcnt;
    if (start || stop || state == IDLE || state == DEVACK ||
        state == RD_LOAD || state == RACK)
      bit_nxt = 4'd0;
    else if (shift_en || rd_shift)
      bit_nxt = bitcnt + 4'd1;
    else if (byte_done)
      bit_nxt = 4'd9;
    else if (ack_done || rd_end)
      bit_nxt = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (commit) mem[ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_pull <= 1'b0;
      bitcnt   <= '0;
      shift    <= '0;
      ptr      <= '0;
      pulse    <= 1'b0;
      waddr    <= '0;
      wbyte    <= '0;
      busy_st  <= 1'b0;
`ifdef I2C_SLAVE_ADDR16_EN
      hi       <= '0;
`endif
    end else begin
      sda_pull <= pull_nxt;
      bitcnt   <= bit_nxt;
      pulse    <= commit;
      if (commit) begin
        waddr <= 16'(ptr);
        wbyte <= shift;
      end
      if (shift_en)      shift <= {shift[6:0], sda_f};
      else if (rd_ld)    shift <= mem[ptr];
      else if (rd_shift) shift <= {shift[6:0], 1'b0};
`ifdef I2C_SLAVE_ADDR16_EN
      if (state == WA_H && byte_done) hi <= shift;
      if (ld_lo) ptr <= AW'({hi, shift});
`else
      if (ld_lo) ptr <= AW'(shift);
`endif
      else if (commit || rd_end) ptr <= ptr + AW'(1);
      if (busy_set)      busy_st <= 1'b1;
      else if (busy_clr) busy_st <= 1'b0;
    end
  end
endmodule
